// File: rtl/vblank_write_queue_pkg.sv
// Shared definitions for the vertical-blank write queue.
// Contents:
//   state_t - commit FSM encoding (IDLE, COMMIT, CLOSE)
//   clog2   - ceiling log2, used to size counters from parameters
package vblank_write_queue_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        CLOSE  = 2'd2
    } state_t;

    // Smallest number of bits that can index 'value' distinct items.
    function automatic int clog2(input int value);
        int result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/vblank_write_queue_if.sv
// Bus bundle between the CPU/VGA side and the vertical-blank write queue.
// Signals:
//   req_valid/req_addr/req_data/req_ready - CPU update request handshake
//   vga_vs, vga_blank_n                   - timing taps from VGA control
//   mem_gnt/mem_we/mem_addr/mem_wdata     - write port toward shared memory
//   pending, frame_done                   - occupancy and window-closed status
// Modports:
//   master - the environment (CPU, VGA timing, memory arbiter)
//   slave  - the write queue itself
interface vblank_write_queue_if #(
    parameter int SYS_DATA_WIDTH = 16,
    parameter int SYS_ADDR_WIDTH = 16,
    parameter int LOG2_DEPTH     = 4
);

    logic                      req_valid;
    logic [SYS_ADDR_WIDTH-1:0] req_addr;
    logic [SYS_DATA_WIDTH-1:0] req_data;
    logic                      req_ready;
    logic                      vga_vs;
    logic                      vga_blank_n;
    logic                      mem_gnt;
    logic                      mem_we;
    logic [SYS_ADDR_WIDTH-1:0] mem_addr;
    logic [SYS_DATA_WIDTH-1:0] mem_wdata;
    logic [LOG2_DEPTH:0]       pending;
    logic                      frame_done;

    modport master (
        output req_valid, req_addr, req_data, vga_vs, vga_blank_n, mem_gnt,
        input  req_ready, mem_we, mem_addr, mem_wdata, pending, frame_done
    );

    modport slave (
        input  req_valid, req_addr, req_data, vga_vs, vga_blank_n, mem_gnt,
        output req_ready, mem_we, mem_addr, mem_wdata, pending, frame_done
    );

endinterface

// File: rtl/vblank_write_queue_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and occupancy count.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   push, push_data     - write side; ignored while full
//   pop, head_data      - read side; head_data is the oldest entry
//   full, empty, count  - registered status, count ranges 0..2**LOG2_DEPTH
module sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int LOG2_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_data,
    input  logic                pop,
    output logic [WIDTH-1:0]    head_data,
    output logic                full,
    output logic                empty,
    output logic [LOG2_DEPTH:0] count
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [WIDTH-1:0]      storage [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic [LOG2_DEPTH:0]   count_next;
    logic                  do_push;
    logic                  do_pop;

    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = storage[rd_ptr];

    // A simultaneous push and pop leaves the occupancy unchanged.
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointers are exactly LOG2_DEPTH bits wide so they wrap modulo DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (LOG2_DEPTH + 1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Storage needs no reset; empty/count guard against stale contents.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vblank_write_queue.sv
// Buffers CPU tile-map/colour updates and commits them to shared memory only
// during vertical blanking, so the display path never sees a torn frame.
// Ports:
//   clk    - system clock shared with VGA control
//   reset  - asynchronous active-low reset; discards any queued updates
//   bus    - slave side of vblank_write_queue_if (request handshake, VGA
//            timing taps, memory write port, pending count, frame_done)
module vblank_write_queue
    import vblank_write_queue_pkg::*;
#(
    parameter int SYS_DATA_WIDTH = 16,
    parameter int SYS_ADDR_WIDTH = 16,
    parameter int LOG2_DEPTH     = 4,
    parameter int MAX_WRITES     = 64
) (
    input  logic                clk,
    input  logic                reset,
    vblank_write_queue_if.slave bus
);

    localparam int ENTRY_WIDTH = SYS_ADDR_WIDTH + SYS_DATA_WIDTH;
    localparam int WCNT_WIDTH  = clog2(MAX_WRITES + 1);
    localparam logic [WCNT_WIDTH-1:0] LAST_WRITE = WCNT_WIDTH'(MAX_WRITES - 1);

    state_t                 state;
    state_t                 state_next;
    logic [WCNT_WIDTH-1:0]  wcnt;
    logic [WCNT_WIDTH-1:0]  wcnt_next;
    logic                   vs_q;
    logic                   vs_fall;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [LOG2_DEPTH:0]    fifo_count;
    logic [ENTRY_WIDTH-1:0] head_entry;
    logic                   push;
    logic                   pop;
    logic                   mem_we;
    logic                   frame_done;
    logic                   drained;
    logic                   hit_max;

    // Falling edge of vsync opens the commit window; vs_q resets high so
    // a low vsync at reset release still needs a real edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) vs_q <= 1'b1;
        else        vs_q <= bus.vga_vs;
    end

    assign vs_fall = vs_q & ~bus.vga_vs;

    assign push = bus.req_valid & ~fifo_full;
    assign pop  = mem_we & bus.mem_gnt;

    sync_fifo #(
        .WIDTH      (ENTRY_WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({bus.req_addr, bus.req_data}),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Window-close conditions look at the FIFO as it will be after this
    // cycle's accepted write, so the last write and the exit share a cycle.
    assign drained = (fifo_empty | (pop & (fifo_count == (LOG2_DEPTH + 1)'(1)))) & ~push;
    assign hit_max = pop & (wcnt == LAST_WRITE);

    // Moore outputs decoded from the current state only.
    always_comb begin
        mem_we     = 1'b0;
        frame_done = 1'b0;
        case (state)
            COMMIT:  mem_we     = ~fifo_empty;
            CLOSE:   frame_done = 1'b1;
            default: ;
        endcase
    end

    // Next-state and write-count logic; a vsync edge outside IDLE is ignored.
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        case (state)
            IDLE: begin
                if (vs_fall) begin
                    state_next = COMMIT;
                    wcnt_next  = '0;
                end
            end
            COMMIT: begin
                if (pop) wcnt_next = wcnt + 1'b1;
                if (bus.vga_blank_n || hit_max || drained) state_next = CLOSE;
            end
            CLOSE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    // Address/data are forced to zero whenever no write is being requested.
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_we ? head_entry[ENTRY_WIDTH-1:SYS_DATA_WIDTH] : '0;
    assign bus.mem_wdata  = mem_we ? head_entry[SYS_DATA_WIDTH-1:0] : '0;
    assign bus.req_ready  = ~fifo_full;
    assign bus.pending    = fifo_count;
    assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_vblank_write_queue.sv
// Directed testbench for vblank_write_queue (instance built with MAX_WRITES=4
// so window cut-off is reachable with a 16-deep FIFO).
module tb_vblank_write_queue;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    vblank_write_queue_if #(.SYS_DATA_WIDTH(16), .SYS_ADDR_WIDTH(16), .LOG2_DEPTH(4)) bus();

    vblank_write_queue #(
        .SYS_DATA_WIDTH (16),
        .SYS_ADDR_WIDTH (16),
        .LOG2_DEPTH     (4),
        .MAX_WRITES     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Record every write the memory accepts, in order.
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1 && bus.mem_gnt === 1'b1)
            got_q.push_back({bus.mem_addr, bus.mem_wdata});
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Push n consecutive entries, each expected to be accepted immediately.
    task automatic push_burst(input int n, input logic [15:0] addr0, input logic [15:0] data0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== 1'b1) begin
                fails++;
                $display("[TB] FAIL push_ready entry %0d: req_ready=%b expected 1", i, bus.req_ready);
            end
            bus.req_valid = 1'b1;
            bus.req_addr  = addr0 + 16'(i);
            bus.req_data  = data0 + 16'(i);
            exp_q.push_back({bus.req_addr, bus.req_data});
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Open one blanking window and check the accepted writes against the model.
    task automatic run_window(input int n_expected, input bit toggle, input string tag);
        bit          seen = 1'b0;
        bit          hold = 1'b0;
        logic [15:0] ha = '0;
        logic [15:0] hd = '0;
        logic [31:0] exp_entry;
        got_q.delete();
        @(negedge clk);
        bus.vga_vs      = 1'b0;
        bus.vga_blank_n = 1'b0;
        bus.mem_gnt     = 1'b1;
        for (int cyc = 0; cyc < 64 && !seen; cyc++) begin
            @(negedge clk);
            if (hold) begin
                checks++;
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== ha || bus.mem_wdata !== hd) begin
                    fails++;
                    $display("[TB] FAIL %s hold_stable: we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                             tag, bus.mem_we, bus.mem_addr, bus.mem_wdata, ha, hd);
                end
            end
            if (bus.frame_done === 1'b1) seen = 1'b1;
            bus.mem_gnt = toggle ? ((cyc % 2) == 1) : 1'b1;
            hold = (bus.mem_we === 1'b1) && !bus.mem_gnt;
            ha   = bus.mem_addr;
            hd   = bus.mem_wdata;
        end
        bus.vga_vs      = 1'b1;
        bus.vga_blank_n = 1'b1;
        bus.mem_gnt     = 1'b1;
        checks++;
        if (!seen) begin
            fails++;
            $display("[TB] FAIL %s window_timeout: frame_done not seen, expected within 64 cycles", tag);
        end
        checks++;
        if (got_q.size() != n_expected) begin
            fails++;
            $display("[TB] FAIL %s write_count: got %0d expected %0d", tag, got_q.size(), n_expected);
        end
        foreach (got_q[i]) begin
            exp_entry = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (got_q[i] !== exp_entry) begin
                fails++;
                $display("[TB] FAIL %s write_order[%0d]: got %h expected %h", tag, i, got_q[i], exp_entry);
            end
        end
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        bus.req_valid   = 1'b1;
        bus.req_addr    = 16'hDEAD;
        bus.req_data    = 16'hBEEF;
        bus.vga_vs      = 1'b1;
        bus.vga_blank_n = 1'b1;
        bus.mem_gnt     = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.mem_we !== 1'b0 || bus.pending !== 5'd0) begin
            fails++;
            $display("[TB] FAIL reset_state: ready=%b we=%b pending=%0d expected ready=1 we=0 pending=0",
                     bus.req_ready, bus.mem_we, bus.pending);
        end
        checks++;
        if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0 || bus.frame_done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: addr=%h data=%h frame_done=%b expected 0 0 0",
                     bus.mem_addr, bus.mem_wdata, bus.frame_done);
        end
        bus.req_valid = 1'b0;
        bus.mem_gnt   = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        push_burst(3, 16'h0020, 16'h2000);
        checks++;
        if (bus.pending !== 5'd3) begin
            fails++;
            $display("[TB] FAIL active_video_pending: got %0d expected 3", bus.pending);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_we !== 1'b0) begin
                fails++;
                $display("[TB] FAIL active_video_no_write cycle %0d: mem_we=%b expected 0", i, bus.mem_we);
            end
        end
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (bus.pending !== 5'd0) begin
            fails++;
            $display("[TB] FAIL reset_discard: pending=%0d expected 0", bus.pending);
        end
    endtask

    task automatic test_window_commit();
        push_burst(1, 16'h0010, 16'hAAAA);
        push_burst(1, 16'h0011, 16'hBBBB);
        exp_q.delete();
        @(negedge clk);
        bus.vga_vs      = 1'b0;
        bus.vga_blank_n = 1'b0;
        bus.mem_gnt     = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0010 || bus.mem_wdata !== 16'hAAAA) begin
            fails++;
            $display("[TB] FAIL commit_first: we=%b addr=%h data=%h expected 1 0010 aaaa",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0011 || bus.mem_wdata !== 16'hBBBB) begin
            fails++;
            $display("[TB] FAIL commit_second: we=%b addr=%h data=%h expected 1 0011 bbbb",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (bus.mem_we !== 1'b0 || bus.frame_done !== 1'b1 || bus.pending !== 5'd0) begin
            fails++;
            $display("[TB] FAIL commit_close: we=%b frame_done=%b pending=%0d expected 0 1 0",
                     bus.mem_we, bus.frame_done, bus.pending);
        end
        @(negedge clk);
        checks++;
        if (bus.frame_done !== 1'b0 || bus.mem_we !== 1'b0) begin
            fails++;
            $display("[TB] FAIL frame_done_width: frame_done=%b we=%b expected 0 0", bus.frame_done, bus.mem_we);
        end
        bus.vga_vs      = 1'b1;
        bus.vga_blank_n = 1'b1;
    endtask

    task automatic test_backpressure();
        push_burst(16, 16'h0100, 16'h3000);
        checks++;
        if (bus.req_ready !== 1'b0 || bus.pending !== 5'd16) begin
            fails++;
            $display("[TB] FAIL full_flag: ready=%b pending=%0d expected 0 16", bus.req_ready, bus.pending);
        end
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h01FF;
        bus.req_data  = 16'h3FFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.pending !== 5'd16) begin
                fails++;
                $display("[TB] FAIL held_17th cycle %0d: pending=%0d expected 16", i, bus.pending);
            end
        end
        bus.req_valid = 1'b0;
        run_window(4, 1'b1, "bp1");
        checks++;
        if (bus.pending !== 5'd12) begin
            fails++;
            $display("[TB] FAIL bp_pending: got %0d expected 12", bus.pending);
        end
        run_window(4, 1'b1, "bp2");
        run_window(4, 1'b0, "bp3");
        run_window(4, 1'b0, "bp4");
        checks++;
        if (bus.pending !== 5'd0) begin
            fails++;
            $display("[TB] FAIL bp_drained: pending=%0d expected 0", bus.pending);
        end
    endtask

    task automatic test_window_cut();
        push_burst(10, 16'h0400, 16'h4000);
        run_window(4, 1'b0, "cut1");
        checks++;
        if (bus.pending !== 5'd6) begin
            fails++;
            $display("[TB] FAIL cut1_pending: got %0d expected 6", bus.pending);
        end
        run_window(4, 1'b0, "cut2");
        checks++;
        if (bus.pending !== 5'd2) begin
            fails++;
            $display("[TB] FAIL cut2_pending: got %0d expected 2", bus.pending);
        end
        run_window(2, 1'b0, "cut3");
    endtask

    task automatic test_active_video_resume();
        int          seen_we = 0;
        logic [31:0] exp_entry;
        push_burst(8, 16'h0500, 16'h5000);
        got_q.delete();
        @(negedge clk);
        bus.vga_vs      = 1'b0;
        bus.vga_blank_n = 1'b0;
        bus.mem_gnt     = 1'b1;
        for (int c = 0; c < 20 && seen_we < 3; c++) begin
            @(negedge clk);
            if (bus.mem_we === 1'b1) seen_we++;
            if (seen_we == 3) bus.vga_blank_n = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (bus.mem_we !== 1'b0 || bus.frame_done !== 1'b1) begin
            fails++;
            $display("[TB] FAIL resume_stop: we=%b frame_done=%b expected 0 1", bus.mem_we, bus.frame_done);
        end
        checks++;
        if (got_q.size() != 3 || bus.pending !== 5'd5) begin
            fails++;
            $display("[TB] FAIL resume_count: writes=%0d pending=%0d expected 3 5", got_q.size(), bus.pending);
        end
        foreach (got_q[i]) begin
            exp_entry = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (got_q[i] !== exp_entry) begin
                fails++;
                $display("[TB] FAIL resume_order[%0d]: got %h expected %h", i, got_q[i], exp_entry);
            end
        end
        bus.vga_vs = 1'b1;
        run_window(4, 1'b0, "resume2");
        run_window(1, 1'b0, "resume3");
    endtask

    task automatic test_async_reset();
        bit reached = 1'b0;
        push_burst(5, 16'h0600, 16'h6000);
        got_q.delete();
        @(negedge clk);
        bus.vga_vs      = 1'b0;
        bus.vga_blank_n = 1'b0;
        bus.mem_gnt     = 1'b1;
        for (int c = 0; c < 20 && !reached; c++) begin
            @(negedge clk);
            if (got_q.size() == 2) reached = 1'b1;
        end
        checks++;
        if (!reached || bus.mem_we !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_commit_setup: writes=%0d we=%b expected 2 1", got_q.size(), bus.mem_we);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0 || bus.pending !== 5'd0 || bus.req_ready !== 1'b1 || bus.mem_addr !== 16'h0) begin
            fails++;
            $display("[TB] FAIL async_reset: we=%b pending=%0d ready=%b addr=%h expected 0 0 1 0000",
                     bus.mem_we, bus.pending, bus.req_ready, bus.mem_addr);
        end
        exp_q.delete();
        bus.vga_vs      = 1'b1;
        bus.vga_blank_n = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_we !== 1'b0 || bus.frame_done !== 1'b0 || bus.pending !== 5'd0) begin
                fails++;
                $display("[TB] FAIL post_reset_idle cycle %0d: we=%b frame_done=%b pending=%0d expected 0 0 0",
                         i, bus.mem_we, bus.frame_done, bus.pending);
            end
        end
    endtask

    initial begin
        test_reset();
        test_window_commit();
        test_backpressure();
        test_window_cut();
        test_active_video_resume();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
